// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic-light controller: times green/yellow in prescaled ticks and
// requests a direction swap. Optional feature macro: PED_REQUEST_EN (pedestrian green cut).
module traffic_phase_timer #(
  parameter int TICK_DIV      = 1000,
  parameter int GREEN_TICKS   = 30,
  parameter int YELLOW_TICKS  = 4,
  parameter int PED_MIN_TICKS = 10,
  parameter int CNT_W         = 16
) (
  input  logic       i_clk,
  input  logic       i_nreset,
  input  logic       i_countEnable,
`ifdef PED_REQUEST_EN
  input  logic       i_pedReq,
`endif
  output logic       o_newState,
  output logic       o_nextLight,
  output logic [2:0] o_phase
);

  typedef enum logic [2:0] {
    KICK    = 3'd0,
    WAIT_LO = 3'd1,
    WAIT_HI = 3'd2,
    GREEN   = 3'd3,
    YELLOW  = 3'd4,
    SWITCH  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    if (PED_MIN_TICKS < 1 || PED_MIN_TICKS > GREEN_TICKS) begin : g_cfg_err
      $error("traffic_phase_timer: PED_MIN_TICKS must lie in 1..GREEN_TICKS");
    end
  endgenerate

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] tick_cnt_r, tick_cnt_s;
  logic [CNT_W-1:0] phase_cnt_r, phase_cnt_s;
  logic             counting_s, tick_s, green_done_s;

`ifdef PED_REQUEST_EN
  localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_MIN_TICKS - 1);
  logic ped_latch_r, ped_latch_s;

  // Green may be cut on any tick once a request is latched and the minimum green has run.
  always_comb begin
    green_done_s = tick_s && ((phase_cnt_r == GREEN_LAST) ||
                              (ped_latch_r && (phase_cnt_r >= PED_LAST)));
  end

  // Sticky pedestrian latch: armed only during GREEN, dropped when YELLOW is entered.
  always_comb begin
    ped_latch_s = ped_latch_r;
    if (state_r == GREEN) begin
      if (next_state_s == YELLOW) begin
        ped_latch_s = 1'b0;
      end else if (i_pedReq) begin
        ped_latch_s = 1'b1;
      end else begin
        ped_latch_s = ped_latch_r;
      end
    end else begin
      ped_latch_s = ped_latch_r;
    end
  end

  // Pedestrian latch register.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      ped_latch_r <= 1'b0;
    end else begin
      ped_latch_r <= ped_latch_s;
    end
  end
`else
  // Green always runs its full length.
  always_comb begin
    green_done_s = tick_s && (phase_cnt_r == GREEN_LAST);
  end
`endif

  // Next-state and counter logic; counters freeze whenever the enable is low.
  always_comb begin
    next_state_s = state_r;
    tick_cnt_s   = tick_cnt_r;
    phase_cnt_s  = phase_cnt_r;
    counting_s   = ((state_r == GREEN) || (state_r == YELLOW)) && i_countEnable;
    tick_s       = counting_s && (tick_cnt_r == TICK_LAST);

    if (counting_s) begin
      if (tick_s) begin
        tick_cnt_s  = CNT_ZERO;
        phase_cnt_s = phase_cnt_r + CNT_ONE;
      end else begin
        tick_cnt_s  = tick_cnt_r + CNT_ONE;
      end
    end else begin
      tick_cnt_s = tick_cnt_r;
    end

    case (state_r)
      KICK:    next_state_s = SWITCH;
      SWITCH:  next_state_s = WAIT_LO;
      WAIT_LO: begin
        if (!i_countEnable) begin
          next_state_s = WAIT_HI;
        end else begin
          next_state_s = WAIT_LO;
        end
      end
      WAIT_HI: begin
        if (i_countEnable) begin
          next_state_s = GREEN;
          tick_cnt_s   = CNT_ZERO;
          phase_cnt_s  = CNT_ZERO;
        end else begin
          next_state_s = WAIT_HI;
        end
      end
      GREEN: begin
        if (green_done_s) begin
          next_state_s = YELLOW;
          phase_cnt_s  = CNT_ZERO;
        end else begin
          next_state_s = GREEN;
        end
      end
      YELLOW: begin
        if (tick_s && (phase_cnt_r == YELLOW_LAST)) begin
          next_state_s = SWITCH;
          phase_cnt_s  = CNT_ZERO;
        end else begin
          next_state_s = YELLOW;
        end
      end
      default: begin
        next_state_s = KICK;
        tick_cnt_s   = CNT_ZERO;
        phase_cnt_s  = CNT_ZERO;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_r     <= KICK;
      tick_cnt_r  <= CNT_ZERO;
      phase_cnt_r <= CNT_ZERO;
      o_newState  <= 1'b0;
      o_nextLight <= 1'b0;
      o_phase     <= 3'd0;
    end else begin
      state_r     <= next_state_s;
      tick_cnt_r  <= tick_cnt_s;
      phase_cnt_r <= phase_cnt_s;
      o_newState  <= (next_state_s == SWITCH);
      o_nextLight <= (next_state_s == YELLOW);
      o_phase     <= next_state_s;
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomized self-checking bench for traffic_phase_timer against an elapsed-cycle reference model.
module tb_traffic_phase_timer;
  localparam int TICK_DIV      = 4;
  localparam int YELLOW_TICKS  = 2;
  localparam int PED_MIN_TICKS = 1;
  localparam int CNT_W         = 16;
`ifdef PED_REQUEST_EN
  localparam int GREEN_TICKS   = 10;
`else
  localparam int GREEN_TICKS   = 3;
`endif

  localparam int S_KICK = 0, S_WAIT_LO = 1, S_WAIT_HI = 2, S_GREEN = 3, S_YELLOW = 4, S_SWITCH = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       ped = 1'b0;
  logic       new_state, next_light;
  logic [2:0] phase;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .TICK_DIV(TICK_DIV), .GREEN_TICKS(GREEN_TICKS), .YELLOW_TICKS(YELLOW_TICKS),
    .PED_MIN_TICKS(PED_MIN_TICKS), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_nreset(rst_n),
    .i_countEnable(en),
`ifdef PED_REQUEST_EN
    .i_pedReq(ped),
`endif
    .o_newState(new_state),
    .o_nextLight(next_light),
    .o_phase(phase)
  );

  int checks = 0;
  int errors = 0;
  int m_state = S_KICK;
  int m_elapsed = 0;
  bit m_latch = 1'b0;
  int ctrl_low = 0;
  bit prev_ns = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: green/yellow end after a number of enabled cycles, not via tick/phase counters.
  task automatic model_step(input bit e, input bit p);
    bit leave;
    leave = 1'b0;
    case (m_state)
      S_KICK:    m_state = S_SWITCH;
      S_SWITCH:  m_state = S_WAIT_LO;
      S_WAIT_LO: if (!e) m_state = S_WAIT_HI;
      S_WAIT_HI: if (e) begin m_state = S_GREEN; m_elapsed = 0; m_latch = 1'b0; end
      S_GREEN: begin
        if (e) begin
          m_elapsed++;
          if (m_elapsed == TICK_DIV * GREEN_TICKS) leave = 1'b1;
`ifdef PED_REQUEST_EN
          if (m_latch && (m_elapsed % TICK_DIV == 0) && (m_elapsed >= PED_MIN_TICKS * TICK_DIV))
            leave = 1'b1;
`endif
        end
        if (leave) begin
          m_state = S_YELLOW; m_elapsed = 0; m_latch = 1'b0;
        end else if (p) begin
          m_latch = 1'b1;
        end
      end
      S_YELLOW: begin
        if (e) begin
          m_elapsed++;
          if (m_elapsed == TICK_DIV * YELLOW_TICKS) begin m_state = S_SWITCH; m_elapsed = 0; end
        end
      end
      default: m_state = S_KICK;
    endcase
  endtask

  // Called at a falling edge: compare, pick inputs for the next rising edge, advance the model.
  task automatic cycle(input bit drop, input bit p);
    check("phase", {29'd0, phase}, m_state);
    check("new_state", {31'd0, new_state}, (m_state == S_SWITCH) ? 1 : 0);
    check("next_light", {31'd0, next_light}, (m_state == S_YELLOW) ? 1 : 0);
    check("ns_consecutive", {31'd0, new_state & prev_ns}, 0);
    check("ns_with_nl", {31'd0, new_state & next_light}, 0);
    prev_ns = new_state;
    if (rst_n && m_state == S_SWITCH) ctrl_low = 2;
    if (ctrl_low > 0) begin
      en = 1'b0;
      ctrl_low--;
    end else begin
      en = !(drop && (m_state == S_GREEN || m_state == S_YELLOW));
    end
    ped = p;
    if (rst_n) model_step(en, ped);
    @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (phase != p[2:0] && n < 200) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("wait_phase", {29'd0, phase}, p);
  endtask

  task automatic run_len(input int p, input int drop_at, input int drop_len, input int ped_at,
                         output int len);
    len = 0;
    while (phase == p[2:0] && len < 200) begin
      cycle((len >= drop_at) && (len < drop_at + drop_len), len == ped_at);
      len++;
    end
  endtask

  initial begin
    int len;
    int pulses;
    int n;

    repeat (2) cycle(1'b0, 1'b0);
    rst_n = 1'b1;

    wait_phase(S_GREEN);
    run_len(S_GREEN, 0, 0, -1, len);
    check("green_len", len, TICK_DIV * GREEN_TICKS);
    run_len(S_YELLOW, 0, 0, -1, len);
    check("yellow_len", len, TICK_DIV * YELLOW_TICKS);
    check("pulse_after_yellow", {31'd0, new_state}, 1);

    wait_phase(S_GREEN);
    run_len(S_GREEN, 4, 5, -1, len);
    check("green_len_held", len, TICK_DIV * GREEN_TICKS + 5);

`ifdef PED_REQUEST_EN
    wait_phase(S_GREEN);
    run_len(S_GREEN, 0, 0, 1, len);
    check("ped_green_len", len, 4);
`endif

    wait_phase(S_YELLOW);
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_new_state", {31'd0, new_state}, 0);
    check("rst_next_light", {31'd0, next_light}, 0);
    check("rst_phase", {29'd0, phase}, 0);
    m_state = S_KICK; m_elapsed = 0; m_latch = 1'b0; ctrl_low = 0; prev_ns = 1'b0;
    @(negedge clk);
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      if (new_state) pulses++;
      cycle(1'b0, 1'b0);
    end
    check("pulses_after_reset", pulses, 1);

    pulses = 0;
    n = 0;
    while (pulses < 100 && n < 20000) begin
      if (new_state) pulses++;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      n++;
    end
    check("random_full_cycles", pulses, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Phase timer for the traffic-light controller (`FsmModule`).
- Consumes the controller's `o_countEnable`.
- Produces the `i_nextLight` level and the `i_newState` pulse that drive it.
- Counts green and yellow intervals in prescaled ticks, then requests a direction swap.
- Sits next to the controller in the intersection top level, on the same clock.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles per timing tick (≥1).
- `GREEN_TICKS`, 30: ticks of green per direction (≥1).
- `YELLOW_TICKS`, 4: ticks of yellow per direction (≥1).
- `PED_MIN_TICKS`, 10: minimum green ticks before a pedestrian request may cut green (≥1, ≤`GREEN_TICKS`). Used only with `PED_REQUEST_EN`.
- `CNT_W`, 16: width of tick and phase counters; must hold max(`TICK_DIV`, `GREEN_TICKS`, `YELLOW_TICKS`).

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` input 1: system clock.
- `i_nreset` input 1: asynchronous active-low reset.
- `i_countEnable` input 1: controller's count enable; timing advances only while high.
- `i_pedReq` input 1: pedestrian request, level-sampled. Present only with `PED_REQUEST_EN`.
- `o_newState` output 1: one-cycle swap request to the controller.
- `o_nextLight` output 1: high for the whole yellow interval.
- `o_phase` output 3: current state encoding, for debug.

## Operation
States and `o_phase` encodings:
- KICK=0: start-up state.
- WAIT_LO=1: wait for controller to drop count enable.
- WAIT_HI=2: wait for controller to raise count enable.
- GREEN=3: green interval.
- YELLOW=4: yellow interval.
- SWITCH=5: swap request.

Reset:
- All outputs 0.
- Tick counter, phase counter and pedestrian latch 0.
- State KICK.

Transitions:
- **KICK → SWITCH**, unconditional. This starts the controller after reset.
- **SWITCH → WAIT_LO.** `o_newState`=1 for exactly this one cycle; `o_nextLight`=0.
- **WAIT_LO → WAIT_HI** when `i_countEnable`=0. This skips the stale enable left over from before the swap.
- **WAIT_HI → GREEN** when `i_countEnable`=1. Counters clear on entry.
- **GREEN → YELLOW** on a tick when phase count = `GREEN_TICKS`-1. Phase counter clears.
- **YELLOW → SWITCH** on a tick when phase count = `YELLOW_TICKS`-1.

Counting:
- Tick counter runs 0..`TICK_DIV`-1 only in GREEN/YELLOW with `i_countEnable`=1.
- A tick is the cycle in which the counter equals `TICK_DIV`-1; the counter wraps to 0 on that cycle.
- Phase counter increments on each tick.
- `i_countEnable` low in GREEN/YELLOW: both counters hold and the state holds. There is no error and no restart.
- All counter compares are unsigned at `CNT_W` bits. Counters never exceed their terminal value.

Outputs:
- All outputs are registered and decoded from the next state. `o_nextLight` is high exactly while the state is YELLOW.
- `o_newState` is never high on two consecutive cycles.
- `o_newState` and `o_nextLight` are never high together.
- Reset asserted mid-interval returns to KICK immediately. The first action after release is the swap pulse.

## Timing
- `o_newState` rises on the first `i_clk` edge after `i_nreset` deasserts; it is high for 1 cycle.
- Green lasts `TICK_DIV`×`GREEN_TICKS` enabled cycles. Yellow lasts `TICK_DIV`×`YELLOW_TICKS` enabled cycles.
- `o_nextLight` rises on the cycle after the final green tick and falls on the cycle `o_newState` rises.
- Controller round trip: SWITCH, then `i_countEnable` low, then high. With the standard controller, 3 cycles from `o_newState` to GREEN entry.

## Configuration
- `PED_REQUEST_EN` defined:
  - `i_pedReq` exists.
  - A high sample during GREEN sets a sticky latch.
  - GREEN exits on any tick where the latch is set and phase count ≥ `PED_MIN_TICKS`-1.
  - The latch clears on entry to YELLOW; requests in other states are ignored.
- `PED_REQUEST_EN` undefined:
  - Port and latch are absent.
  - Green always runs `GREEN_TICKS`.

## Test plan
Unless noted, the bench uses `TICK_DIV`=4, `GREEN_TICKS`=3, `YELLOW_TICKS`=2, and a controller model that echoes `i_countEnable` per the controller protocol.
- Release reset: `o_newState`=1 on first edge for 1 cycle; `o_phase` passes 1, 2, then 3.
- Full cycle:
  - GREEN holds 12 cycles with `o_nextLight`=0.
  - `o_nextLight`=1 for 8 cycles.
  - `o_newState` pulse follows; `o_nextLight`=0 that cycle.
- Drop `i_countEnable` for 5 cycles mid-GREEN: green extends to 17 cycles and the counters resume from their held values.
- Assert `i_nreset`=0 mid-YELLOW: outputs 0 asynchronously; after release, `o_newState` pulses once.
- With `PED_REQUEST_EN`, `PED_MIN_TICKS`=1, `GREEN_TICKS`=10: pulse `i_pedReq` in cycle 2 of GREEN, and yellow starts after 4 green cycles.
- Run 100 full cycles: `o_newState` never high on consecutive cycles, and never high together with `o_nextLight`.
